parity_frame_checker: RTL and testbench

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

---
 rtl/parity_frame_checker_if.sv | 25 ++
 rtl/parity_frame_checker.sv | 129 ++++++++++++
 tb/tb_parity_frame_checker.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_checker_if.sv
// Handshake and result bundle for parity_frame_checker.
// master = word producer / result consumer, slave = the checker itself.
interface parity_frame_checker_if #(
    parameter int WIDTH = 8
);
    logic             mode_odd;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_err;
    logic [WIDTH-1:0] out_err_mask;
    logic [7:0]       err_cnt;

    modport master (
        output mode_odd, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_err, out_err_mask, err_cnt
    );

    modport slave (
        input  mode_odd, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_err, out_err_mask, err_cnt
    );
endinterface

// File: rtl/parity_frame_checker.sv
// Column-parity frame checker: XORs FRAME_LEN data words, compares against a
// trailing parity word and reports a per-column mismatch mask plus an error count.
module parity_frame_checker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    parity_frame_checker_if.slave  bus_if
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ACC = 2'd0,
        CHK = 2'd1,
        RES = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic             mode_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_err_q;
    logic [WIDTH-1:0] out_err_mask_q;
    logic [7:0]       err_cnt_q;

    logic             xfer_s;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mask_d;

    function automatic logic [WIDTH-1:0] expected_parity(
        input logic [WIDTH-1:0] acc,
        input logic             odd
    );
        return odd ? ~acc : acc;
    endfunction

    function automatic logic [WIDTH-1:0] column_mismatch(
        input logic [WIDTH-1:0] parity_word,
        input logic [WIDTH-1:0] acc,
        input logic             odd
    );
        return parity_word ^ expected_parity(acc, odd);
    endfunction

    // in_ready_q is held low for the first edge after reset release so that edge never transfers
    assign xfer_s = bus_if.in_valid & in_ready_q;

    // Datapath next values: running XOR (first word loads) and the mismatch mask
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        acc_d  = acc_q;
        mask_d = column_mismatch(bus_if.in_data, acc_q, mode_q);
        if (cnt_q == CW'(0)) begin
            acc_d = bus_if.in_data;
        end else begin
            acc_d = acc_q ^ bus_if.in_data;
        end
    end

    // Frame FSM with all handshake and result outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ACC;
            cnt_q          <= CW'(0);
            acc_q          <= {WIDTH{1'b0}};
            mode_q         <= 1'b0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            out_err_q      <= 1'b0;
            out_err_mask_q <= {WIDTH{1'b0}};
            err_cnt_q      <= 8'd0;
        end else begin
            case (state_q)
                ACC: begin
                    in_ready_q <= 1'b1;
                    if (xfer_s) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (cnt_q == CW'(0)) begin
                            mode_q <= bus_if.mode_odd;
                        end
                        if (cnt_d == CW'(FRAME_LEN)) begin
                            state_q <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (xfer_s) begin
                        out_err_mask_q <= mask_d;
                        out_err_q      <= |mask_d;
                        out_valid_q    <= 1'b1;
                        in_ready_q     <= 1'b0;
                        state_q        <= RES;
                        if ((|mask_d) && (err_cnt_q != 8'hFF)) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RES: begin
                    in_ready_q <= 1'b0;
                    if (bus_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= CW'(0);
                        in_ready_q  <= 1'b1;
                        state_q     <= ACC;
                    end
                end
                default: begin
                    state_q     <= ACC;
                    cnt_q       <= CW'(0);
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.in_ready     = in_ready_q;
    assign bus_if.out_valid    = out_valid_q;
    assign bus_if.out_err      = out_err_q;
    assign bus_if.out_err_mask = out_err_mask_q;
    assign bus_if.err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker (WIDTH=8, FRAME_LEN=4) with directed frames.
module tb_parity_frame_checker;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct {
        logic       err;
        logic [7:0] mask;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cnt_model;
    logic       prev_valid;

    parity_frame_checker_if #(.WIDTH(8)) bus();

    parity_frame_checker #(.WIDTH(8), .FRAME_LEN(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare each newly presented result against the scoreboard head
    initial begin
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got out_valid 1 expected no pending result at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_err", 32'(bus.out_err), 32'(e.err));
                    chk("out_err_mask", 32'(bus.out_err_mask), 32'(e.mask));
                    chk("err_cnt", 32'(bus.err_cnt), 32'(e.cnt));
                end
            end
            prev_valid = rst_n & bus.out_valid;
        end
    end

    task automatic send_word(input logic [7:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 50 cycles at %0t", $time);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Data is always 01,02,04,08: XOR = 0F, so even parity 0F, odd parity F0
    task automatic send_frame(input logic odd, input logic toggle,
                              input logic [7:0] par, input logic [7:0] mask);
        exp_t e;
        bus.mode_odd = odd;
        send_word(8'h01);
        if (toggle) bus.mode_odd = ~odd;
        send_word(8'h02);
        send_word(8'h04);
        send_word(8'h08);
        if (mask != 8'h00 && cnt_model != 8'hFF) cnt_model = cnt_model + 8'd1;
        e.err  = (mask != 8'h00);
        e.mask = mask;
        e.cnt  = cnt_model;
        exp_q.push_back(e);
        send_word(par);
        chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cnt_model = 8'd0;
        rst_n = 1'b0;
        bus.mode_odd  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_mask", 32'(bus.out_err_mask), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        // Word presented across the release edge must not be taken as data
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        send_frame(1'b0, 1'b0, 8'h0F, 8'h00);   // even, good
        send_frame(1'b1, 1'b0, 8'hF0, 8'h00);   // odd, good
        send_frame(1'b0, 1'b1, 8'h0F, 8'h00);   // even latched, toggled mid-frame
        send_frame(1'b1, 1'b1, 8'hF0, 8'h00);   // odd latched, toggled mid-frame
        send_frame(1'b0, 1'b0, 8'h0E, 8'h01);   // even, column 0 wrong
        @(posedge clk);
        #1;
        chk("retain_out_err", 32'(bus.out_err), 32'd1);
        chk("retain_mask", 32'(bus.out_err_mask), 32'h01);

        // Stall result: inputs must be refused and result held
        bus.out_ready = 1'b0;
        send_frame(1'b0, 1'b0, 8'h0F, 8'h00);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hAA;
            @(posedge clk);
            #1;
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_mask", 32'(bus.out_err_mask), 32'h00);
            chk("hold_err_cnt", 32'(bus.err_cnt), 32'd1);
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        send_frame(1'b0, 1'b0, 8'h0F, 8'h00);

        // Reset after two data words discards the partial frame
        bus.mode_odd = 1'b0;
        send_word(8'h55);
        send_word(8'h33);
        rst_n = 1'b0;
        #1;
        chk("async_rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("async_rst_mask", 32'(bus.out_err_mask), 32'd0);
        cnt_model = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(1'b0, 1'b0, 8'h0F, 8'h00);

        // Saturation of the error counter
        for (int i = 0; i < 256; i++) begin
            send_frame(1'b0, 1'b0, 8'h0E, 8'h01);
        end
        @(posedge clk);
        #1;
        chk("sat_err_cnt", 32'(bus.err_cnt), 32'd255);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
